// File: rtl/pipeline_chain.sv
// pipeline_chain: DEPTH register slices with valid/ready on both sides, flush and occupancy count.
// Define PIPELINE_CHAIN_SKID_EN to give each slice a skid register and a registered ready.
module pipeline_chain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(2*DEPTH+1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_in_valid,
    output logic             data_in_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_out_valid,
    input  logic             data_out_ready,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);
`ifdef PIPELINE_CHAIN_SKID_EN
    localparam int CAP = 2*DEPTH;
`else
    localparam int CAP = DEPTH;
`endif

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];
    logic             in_hs, out_hs;
    logic [CNT_W-1:0] count_q, count_d;

    assign data_in_ready = rdy[0] & ~rst_i & ~flush_i;
    assign in_hs         = data_in_valid & data_in_ready;
    assign out_hs        = v_q[DEPTH-1] & data_out_ready;

    // Upstream view of each slice: the input port for slice 0, the previous slice otherwise.
    always_comb begin
        up_v[0] = in_hs;
        up_d[0] = data_in;
        for (int k = 1; k < DEPTH; k++) begin
            up_v[k] = v_q[k-1];
            up_d[k] = d_q[k-1];
        end
    end

`ifndef PIPELINE_CHAIN_SKID_EN
    // Slice k can accept if any slice from k to the output has a hole or the consumer takes.
    always_comb begin
        rdy[DEPTH] = data_out_ready;
        for (int k = 0; k < DEPTH; k++) begin
            rdy[k] = data_out_ready | (|(~v_q >> k));
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (up_v[k] && rdy[k]) begin
                v_d[k] = 1'b1;
                d_d[k] = up_d[k];
            end else if (rdy[k+1]) begin
                v_d[k] = 1'b0;
            end
        end
    end
`else
    logic [DEPTH-1:0] sv_q, sv_d;
    logic [WIDTH-1:0] sd_q [DEPTH];
    logic [WIDTH-1:0] sd_d [DEPTH];

    assign rdy = {data_out_ready, ~sv_q};

    // A full skid implies a full main register, so the skid always drains into main first.
    always_comb begin
        v_d  = v_q;
        d_d  = d_q;
        sv_d = sv_q;
        sd_d = sd_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (sv_q[k]) begin
                if (rdy[k+1]) begin
                    d_d[k]  = sd_q[k];
                    sv_d[k] = 1'b0;
                end
            end else if (up_v[k]) begin
                if (!v_q[k] || rdy[k+1]) begin
                    v_d[k] = 1'b1;
                    d_d[k] = up_d[k];
                end else begin
                    sv_d[k] = 1'b1;
                    sd_d[k] = up_d[k];
                end
            end else if (rdy[k+1]) begin
                v_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sv_q <= '0;
            sd_q <= '{default: '0};
        end else begin
            sv_q <= flush_i ? '0 : sv_d;
            sd_q <= sd_d;
        end
    end
`endif

    always_comb begin
        count_d = count_q;
        if (in_hs && !out_hs) begin
            count_d = count_q + CNT_W'(1);
        end else if (out_hs && !in_hs) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q     <= '0;
            d_q     <= '{default: '0};
            count_q <= '0;
        end else begin
            v_q     <= flush_i ? '0 : v_d;
            d_q     <= d_d;
            count_q <= flush_i ? '0 : count_d;
        end
    end

    assign data_out       = d_q[DEPTH-1];
    assign data_out_valid = v_q[DEPTH-1];
    assign count_o        = count_q;
    assign empty_o        = (count_q == '0);
    assign full_o         = (count_q == CNT_W'(CAP));

    // Occupancy leaving [0, CAP] means the handshake logic has lost or invented an item.
    assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        !(in_hs && !out_hs && count_q == CNT_W'(CAP)));
    assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        !(out_hs && !in_hs && count_q == '0));
endmodule

// File: tb/tb_pipeline_chain.sv
// Bench for pipeline_chain (WIDTH=8, DEPTH=3): directed stimulus, queue scoreboard checked by a monitor.
module tb_pipeline_chain;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int CNT_W = $clog2(2*DEPTH+1);
`ifdef PIPELINE_CHAIN_SKID_EN
    localparam int CAP = 2*DEPTH;
`else
    localparam int CAP = DEPTH;
`endif

    logic             clk = 1'b0;
    logic             rst_i, flush_i;
    logic [WIDTH-1:0] data_in, data_out;
    logic             data_in_valid, data_in_ready;
    logic             data_out_valid, data_out_ready;
    logic [CNT_W-1:0] count_o;
    logic             empty_o, full_o;

    int               n_checks = 0;
    int               n_fail = 0;
    logic [7:0]       exp_q [$];
    logic             stall_prev = 1'b0;
    logic [7:0]       stall_d = 8'h00;

    always #5 clk = ~clk;

    pipeline_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .count_o        (count_o),
        .empty_o        (empty_o),
        .full_o         (full_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: held output must stay stable; every output handshake pops the scoreboard.
    always @(negedge clk) begin
        logic [7:0] e;
        if (stall_prev) begin
            n_checks++;
            if (!data_out_valid || data_out !== stall_d) begin
                n_fail++;
                $display("FAIL hold_stable: got valid=%0b data=%02h, required valid=1 data=%02h",
                         data_out_valid, data_out, stall_d);
            end
        end
        stall_prev = !rst_i && !flush_i && data_out_valid && !data_out_ready;
        stall_d    = data_out;
        if (!rst_i && data_out_valid && data_out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_order: got %02h, required no output", data_out);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    n_fail++;
                    $display("FAIL out_order: got %02h, required %02h", data_out, e);
                end
            end
        end
    end

    task automatic push_wait(input logic [7:0] val);
        int waited = 0;
        data_in       = val;
        data_in_valid = 1'b1;
        @(negedge clk);
        while (!data_in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!data_in_ready) begin
            n_fail++;
            $display("FAIL push_timeout: item %02h saw ready=0, required 1", val);
        end else begin
            exp_q.push_back(val);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_left", exp_q.size(), 0);
        @(negedge clk);
        check("drain_empty", empty_o, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; data_in = 8'h5A; data_in_valid = 1'b1; data_out_ready = 1'b0;

        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_in_ready", data_in_ready, 0);
            check("rst_out_valid", data_out_valid, 0);
            check("rst_count", count_o, 0);
            check("rst_empty", empty_o, 1);
            check("rst_full", full_o, 0);
            check("rst_data_out", data_out, 0);
        end
        @(posedge clk); #1;
        rst_i = 1'b0; data_in_valid = 1'b0; data_out_ready = 1'b1;

        // Streaming 01..0A: first output two cycles after acceptance, count capped at 3.
        for (int i = 0; i < 14; i++) begin
            data_in_valid = (i < 10);
            data_in       = 8'(i + 1);
            @(negedge clk);
            check("stream_count", count_o, (i < 3) ? i : ((i <= 10) ? 3 : 13 - i));
            check("stream_valid", data_out_valid, (i >= 3 && i <= 12));
            if (i < 10) begin
                check("stream_in_ready", data_in_ready, 1);
                exp_q.push_back(8'(i + 1));
            end
            @(posedge clk); #1;
        end
        check("stream_drained", exp_q.size(), 0);

        // Fill with the consumer stalled until ready drops.
        data_out_ready = 1'b0;
        for (int j = 0; j <= CAP; j++) begin
            data_in_valid = 1'b1;
            data_in       = 8'(8'h21 + j);
            @(negedge clk);
            check("fill_count", count_o, j);
            check("fill_ready", data_in_ready, (j < CAP));
            check("fill_full", full_o, (j == CAP));
            if (j < CAP) exp_q.push_back(8'(8'h21 + j));
            @(posedge clk); #1;
        end

        // Release the consumer while still pushing.
        data_out_ready = 1'b1;
`ifndef PIPELINE_CHAIN_SKID_EN
        for (int j = 0; j < 6; j++) begin
            data_in_valid = 1'b1;
            data_in       = 8'(8'h40 + j);
            @(negedge clk);
            check("simul_count", count_o, CAP);
            check("simul_ready", data_in_ready, 1);
            check("simul_out_valid", data_out_valid, 1);
            exp_q.push_back(8'(8'h40 + j));
            @(posedge clk); #1;
        end
`else
        for (int j = 0; j < 6; j++) push_wait(8'(8'h40 + j));
`endif
        data_in_valid = 1'b0;
        drain(40);

        // Flush two held items together with an offered AA; none of them may appear.
        data_out_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            data_in_valid = 1'b1;
            data_in       = 8'(8'h51 + j);
            @(negedge clk);
            check("flush_pre_ready", data_in_ready, 1);
            @(posedge clk); #1;
        end
        flush_i = 1'b1; data_in = 8'hAA; data_in_valid = 1'b1;
        @(negedge clk);
        check("flush_pre_count", count_o, 2);
        check("flush_in_ready", data_in_ready, 0);
        @(posedge clk); #1;
        flush_i = 1'b0; data_in_valid = 1'b0;
        @(negedge clk);
        check("flush_count", count_o, 0);
        check("flush_out_valid", data_out_valid, 0);
        check("flush_empty", empty_o, 1);
        @(posedge clk); #1;
        data_out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        check("flush_idle_count", count_o, 0);
        @(posedge clk); #1;
        push_wait(8'h60);
        data_in_valid = 1'b0;
        drain(20);

        // Reset in the middle of full-rate streaming.
        for (int j = 0; j < 6; j++) begin
            data_in_valid = 1'b1;
            data_in       = 8'(8'h70 + j);
            @(negedge clk);
            check("mid_in_ready", data_in_ready, 1);
            exp_q.push_back(8'(8'h70 + j));
            @(posedge clk); #1;
        end
        rst_i = 1'b1; data_in = 8'h76;
        @(negedge clk);
        check("mid_rst_in_ready", data_in_ready, 0);
        @(posedge clk); #1;
        exp_q.delete();
        rst_i = 1'b0; data_in_valid = 1'b0;
        @(negedge clk);
        check("mid_count", count_o, 0);
        check("mid_out_valid", data_out_valid, 0);
        check("mid_data_out", data_out, 0);
        check("mid_empty", empty_o, 1);
        check("mid_full", full_o, 0);
        @(posedge clk); #1;
        push_wait(8'h80);
        push_wait(8'h81);
        data_in_valid = 1'b0;
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_chain.md
Name: pipeline_chain

Overview:
- Parametrised successor to the single-slice valid/ready pipeline register: a chain of DEPTH register slices with a common handshake on each side.
- Adds a synchronous flush, occupancy reporting and an optional skid-buffer mode.
- In skid mode no combinational path runs from data_out_ready to data_in_ready.
- Sits between any two valid/ready producers and consumers for timing closure or latency balancing.

Parameters:
- WIDTH, 8, payload width in bits (>=1).
- DEPTH, 2, number of register slices (>=1). Minimum latency in cycles.
- CNT_W, $clog2(2*DEPTH+1), width of count_o. Derived; do not override.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- flush_i  input  1  synchronous discard of all held data.
- data_in  input  WIDTH  upstream payload.
- data_in_valid  input  1  upstream valid.
- data_in_ready  output  1  block can accept this cycle.
- data_out  output  WIDTH  downstream payload.
- data_out_valid  output  1  data_out holds a valid item.
- data_out_ready  input  1  downstream accepts.
- count_o  output  CNT_W  number of items currently held.
- empty_o  output  1  count_o == 0.
- full_o  output  1  count_o == CAP.

Behaviour:
- One clock; reset is synchronous and active-high.
- rst_i high at a clock edge:
  - all slice valid bits (and skid valid bits) go to 0; all data registers go to 0.
  - count_o = 0, empty_o = 1, full_o = 0, data_out_valid = 0, data_out = 0.
  - data_in_ready = 0 during any cycle with rst_i high.
  - rst_i asserted mid-transfer discards everything in flight; there is no partial drain.
- Handshakes:
  - Input handshake = data_in_valid & data_in_ready.
  - Output handshake = data_out_valid & data_out_ready.
  - Once data_out_valid is asserted, it and data_out stay stable until the output handshake completes.
  - data_in_ready does not depend on data_in_valid.
- Slice k (0 = input side, DEPTH-1 = output side) holds v[k] and d[k]:
  - It loads from slice k-1 (or from the input for k = 0) when the upstream is valid and slice k is ready.
  - It clears when it hands off and receives nothing.
  - Hand-off and load in the same cycle are allowed; d[k] takes the new value.
- Latency: an item accepted at edge N appears on data_out after edge N+DEPTH-1, visible in cycle N+DEPTH-1, provided the chain is not stalled. Sustained throughput is 1 item per cycle.
- Ordering: strict FIFO order. No item is duplicated or dropped, except by flush or reset.
- CAP = DEPTH without PIPELINE_CHAIN_SKID_EN, and 2*DEPTH with it.
- count_o:
  - Registered; +1 on input handshake only, -1 on output handshake only, unchanged when both or neither occur.
  - Saturation cannot occur; reaching CAP+1 or going below 0 is an assertion failure.
- flush_i high at an edge:
  - all valid bits clear and count_o goes to 0.
  - data_in_ready = 0 during that cycle, so no input handshake occurs.
  - An output handshake in the flush cycle is still a legal transfer of the item shown.
  - rst_i has priority over flush_i.
- Full condition: with all slices valid and data_out_ready = 0, data_in_ready = 0.
- Simultaneous push and pop when full: accepted; count_o stays unchanged.

Optional Feature:
- Macro: PIPELINE_CHAIN_SKID_EN.
- Without the macro:
  - slice k ready = ~v[k] | ready[k+1]; ready[DEPTH] = data_out_ready.
  - The ready path is a combinational chain; CAP = DEPTH.
- With the macro:
  - Each slice adds one skid register (sv[k], sd[k]); slice ready = ~sv[k], registered.
  - When a slice is stalled and receives an item, the item goes to the skid register.
  - When the main register drains, the skid content moves to main before any new input.
  - No combinational path from data_out_ready to data_in_ready; CAP = 2*DEPTH.
  - Latency and throughput are unchanged.

Test Plan:
- Reset: rst_i=1 for 2 cycles with data_in_valid=1 -> data_in_ready=0, data_out_valid=0, count_o=0, empty_o=1, data_out=8'h00.
- Streaming: WIDTH=8, DEPTH=3, data_out_ready=1, push 8'h01..8'h0A on consecutive cycles -> first output 8'h01 valid 2 cycles after acceptance, then one item per cycle in order; count_o never exceeds 3.
- Fill: DEPTH=3, data_out_ready=0, push until data_in_ready=0 -> count_o=3 and full_o=1 without the macro; count_o=6 with it. Then release data_out_ready -> all items drain in order.
- Simultaneous: full chain, data_in_valid=1, data_out_ready=1 -> one push and one pop per cycle; count_o stays at CAP and the output sequence has no gaps.
- Flush: 2 items held, flush_i=1 together with data_in_valid=1 (8'hAA) -> next cycle count_o=0 and data_out_valid=0; 8'hAA is never output.
- Mid-operation reset: streaming at full rate, rst_i=1 for 1 cycle -> all outputs return to reset values the next cycle; after reset, the first item pushed is the first item output.
